hw_accel_frame_sched: RTL

Per-frame controller for the grayscale HW accelerator datapath (input FIFO -> hw_accel -> output FIFO -> DMA write). It replaces software toggling of the DMA-init/frame-reset bits. It latches mode and threshold per frame and gates the DMA write path. It counts accepted input pixels and written output words, detects frame completion, timeout and protocol errors, and issues a bounded per-frame datapath reset. It runs in the accelerator clock domain; config and status are synchronised externally.

---
 rtl/hw_accel_frame_sched.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/hw_accel_frame_sched.sv
// Per-frame controller for the grayscale accelerator datapath: sequences LOAD/RUN/FLUSH,
// gates DMA writes, counts pixels/words and raises sticky timeout/overrun/wlast errors.
module hw_accel_frame_sched #(
  parameter int unsigned FRAME_WIDTH         = 640,
  parameter int unsigned FRAME_HEIGHT        = 480,
  parameter int unsigned DMA_TRANSFER_LENGTH = 1920,
  parameter int unsigned FLUSH_CYCLES        = 16,
  parameter int unsigned TIMEOUT_WIDTH       = 24
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cfg_start,
  input  logic        cfg_continuous,
  input  logic        cfg_abort,
  input  logic [1:0]  cfg_mode,
  input  logic [7:0]  cfg_thresh,
  input  logic        err_clr,
  input  logic        in_beat,
  input  logic        out_beat,
  input  logic        out_last,
  output logic        accel_rst,
  output logic [1:0]  accel_mode,
  output logic [7:0]  accel_thresh,
  output logic        dma_write_en,
  output logic        busy,
  output logic        frame_done_irq,
  output logic        timeout_err,
  output logic        in_overrun_err,
  output logic        last_err,
  output logic [15:0] frame_count
);

  localparam int unsigned PIXELS = FRAME_WIDTH * FRAME_HEIGHT;
  localparam int unsigned CW     = $clog2(PIXELS + 1);
  localparam int unsigned XW     = (DMA_TRANSFER_LENGTH > 1) ? $clog2(DMA_TRANSFER_LENGTH) : 1;
  localparam int unsigned FW     = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  localparam logic [CW-1:0] PIX_FULL   = CW'(PIXELS);
  localparam logic [CW-1:0] PIX_LAST   = CW'(PIXELS - 1);
  localparam logic [XW-1:0] XFER_LAST  = XW'(DMA_TRANSFER_LENGTH - 1);
  localparam logic [FW-1:0] FLUSH_LAST = FW'(FLUSH_CYCLES - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_RUN   = 2'd2;
  localparam logic [1:0] S_FLUSH = 2'd3;

  logic [1:0]               r_state;
  logic [1:0]               w_state_nxt;
  logic [CW-1:0]            r_in_cnt;
  logic [CW-1:0]            r_out_cnt;
  logic [XW-1:0]            r_xfer_idx;
  logic [TIMEOUT_WIDTH-1:0] r_wd;
  logic [FW-1:0]            r_flush_cnt;
  logic                     r_done;
  logic                     r_abort_seen;
  logic [1:0]               r_mode;
  logic [7:0]               r_thresh;
  logic                     r_irq;
  logic [15:0]              r_frame_count;
  logic                     r_timeout_err;
  logic                     r_overrun_err;
  logic                     r_last_err;

  logic w_run;
  logic w_in_full;
  logic w_xfer_end;
  logic w_done_hit;
  logic w_wd_expired;
  logic w_last_bad;
  logic w_flush_end;
  logic w_loop;
  logic w_set_timeout;
  logic w_set_overrun;
  logic w_set_last;

  assign w_run        = (r_state == S_RUN);
  assign w_in_full    = (r_in_cnt == PIX_FULL);
  assign w_xfer_end   = (r_xfer_idx == XFER_LAST);
  assign w_done_hit   = out_beat && (r_out_cnt == PIX_LAST);
  assign w_wd_expired = &r_wd;
  assign w_last_bad   = (out_last && (!out_beat || !w_xfer_end)) ||
                        (out_beat && w_xfer_end && !out_last);
  assign w_flush_end  = (r_state == S_FLUSH) && (r_flush_cnt == FLUSH_LAST);
  // An abort arriving on the final FLUSH cycle still cancels the auto-restart.
  assign w_loop       = r_done && cfg_continuous && !r_abort_seen && !cfg_abort;

  // Timeout is only recorded when it is the exit actually taken (lowest priority).
  assign w_set_timeout = w_run && w_wd_expired && !cfg_abort && !w_done_hit;
  assign w_set_overrun = w_run && in_beat && w_in_full;
  assign w_set_last    = w_run && w_last_bad;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (cfg_start && !cfg_abort) w_state_nxt = S_LOAD;
      S_LOAD:  w_state_nxt = S_RUN;
      S_RUN:   if (cfg_abort || w_done_hit || w_wd_expired) w_state_nxt = S_FLUSH;
      S_FLUSH: if (w_flush_end) w_state_nxt = w_loop ? S_LOAD : S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_in_cnt      <= '0;
      r_out_cnt     <= '0;
      r_xfer_idx    <= '0;
      r_wd          <= '0;
      r_flush_cnt   <= '0;
      r_done        <= 1'b0;
      r_abort_seen  <= 1'b0;
      r_mode        <= '0;
      r_thresh      <= 8'd100;
      r_irq         <= 1'b0;
      r_frame_count <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_irq   <= w_flush_end && r_done;
      if (w_flush_end && r_done) r_frame_count <= r_frame_count + 16'd1;
      case (r_state)
        S_LOAD: begin
          r_mode       <= cfg_mode;
          r_thresh     <= cfg_thresh;
          r_in_cnt     <= '0;
          r_out_cnt    <= '0;
          r_xfer_idx   <= '0;
          r_wd         <= '0;
          r_flush_cnt  <= '0;
          r_done       <= 1'b0;
          r_abort_seen <= cfg_abort;
        end
        S_RUN: begin
          if (in_beat && !w_in_full) r_in_cnt <= r_in_cnt + CW'(1);
          if (out_beat) begin
            r_out_cnt  <= r_out_cnt + CW'(1);
            r_xfer_idx <= w_xfer_end ? '0 : r_xfer_idx + XW'(1);
          end
          r_wd        <= (in_beat || out_beat) ? '0 : r_wd + TIMEOUT_WIDTH'(1);
          r_flush_cnt <= '0;
          if (cfg_abort) begin
            r_abort_seen <= 1'b1;
            r_done       <= 1'b0;
          end else if (w_done_hit) begin
            r_done <= 1'b1;
          end
        end
        S_FLUSH: begin
          r_flush_cnt <= r_flush_cnt + FW'(1);
          if (cfg_abort) r_abort_seen <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Sticky flags: a new error in the same cycle as err_clr survives the clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_timeout_err <= 1'b0;
      r_overrun_err <= 1'b0;
      r_last_err    <= 1'b0;
    end else begin
      r_timeout_err <= w_set_timeout || (r_timeout_err && !err_clr);
      r_overrun_err <= w_set_overrun || (r_overrun_err && !err_clr);
      r_last_err    <= w_set_last    || (r_last_err    && !err_clr);
    end
  end

  assign accel_rst      = (r_state == S_IDLE) || (r_state == S_FLUSH);
  assign dma_write_en   = w_run;
  assign busy           = (r_state != S_IDLE);
  assign accel_mode     = r_mode;
  assign accel_thresh   = r_thresh;
  assign frame_done_irq = r_irq;
  assign frame_count    = r_frame_count;
  assign timeout_err    = r_timeout_err;
  assign in_overrun_err = r_overrun_err;
  assign last_err       = r_last_err;

endmodule
